// File: rtl/fir_ctrl.sv
// Sequencer in front of a FIR filter: it holds a coefficient bank, shifts the bank into the filter,
// flushes the filter sum pipeline, then streams samples through while tracking output validity.
module fir_ctrl #(
    parameter int FIR_TAP    = 4,
    parameter int COEF_WIDTH = 8,
    parameter int DIN_WIDTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_we,
    input  logic [$clog2(FIR_TAP)-1:0] cfg_addr,
    input  logic [COEF_WIDTH-1:0]      cfg_data,
    input  logic                       reload,
    input  logic                       s_valid,
    input  logic [DIN_WIDTH-1:0]       s_data,
    output logic                       s_ready,
    output logic                       load_sw,
    output logic [COEF_WIDTH-1:0]      coff_out,
    output logic [DIN_WIDTH-1:0]       fir_din,
    output logic                       out_valid,
    output logic                       busy
);

    localparam int AW = $clog2(FIR_TAP);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LOAD_LAST  = CW'(FIR_TAP - 1);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(FIR_TAP + 1);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         cnt_inc;
    logic                  load_sw_q, load_sw_d;
    logic [COEF_WIDTH-1:0] coff_q, coff_d;
    logic [DIN_WIDTH-1:0]  fir_din_q, fir_din_d;
    logic                  s_ready_q, s_ready_d;
    logic                  busy_q, busy_d;
    logic [1:0]            vpipe_q, vpipe_d;
    logic                  out_valid_q, out_valid_d;
    logic [COEF_WIDTH-1:0] bank_q [FIR_TAP];
    logic [COEF_WIDTH-1:0] bank_d [FIR_TAP];
    logic                  hs;

    always_comb begin
        hs          = s_valid && s_ready_q;
        cnt_inc     = cnt_q + 1'b1;
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_sw_d   = load_sw_q;
        coff_d      = coff_q;
        s_ready_d   = s_ready_q;
        busy_d      = busy_q;
        bank_d      = bank_q;
        fir_din_d   = hs ? s_data : '0;
        // vpipe tracks the fir_din and filter-input stages; out_valid mirrors sum[0].
        vpipe_d     = {vpipe_q[0], hs};
        out_valid_d = vpipe_q[1];

        if (cfg_we && state_q != LOAD && int'(cfg_addr) < FIR_TAP) begin
            bank_d[cfg_addr] = cfg_data;
        end

        case (state_q)
            IDLE: begin
                if (reload) begin
                    state_d   = LOAD;
                    cnt_d     = '0;
                    load_sw_d = 1'b0;
                    coff_d    = bank_q[0];
                    busy_d    = 1'b1;
                end
            end
            LOAD: begin
                if (cnt_q == LOAD_LAST) begin
                    state_d   = FLUSH;
                    cnt_d     = '0;
                    load_sw_d = 1'b1;
                end else begin
                    cnt_d  = cnt_inc;
                    coff_d = bank_q[cnt_inc[AW-1:0]];
                end
            end
            FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    s_ready_d = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RUN: begin
                // Sample taken alongside reload still reaches the filter but never reports valid.
                if (reload) begin
                    state_d   = LOAD;
                    cnt_d     = '0;
                    load_sw_d = 1'b0;
                    coff_d    = bank_q[0];
                    busy_d    = 1'b1;
                    s_ready_d = 1'b0;
                    vpipe_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            load_sw_q   <= 1'b1;
            coff_q      <= '0;
            fir_din_q   <= '0;
            s_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            vpipe_q     <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < FIR_TAP; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            load_sw_q   <= load_sw_d;
            coff_q      <= coff_d;
            fir_din_q   <= fir_din_d;
            s_ready_q   <= s_ready_d;
            busy_q      <= busy_d;
            vpipe_q     <= vpipe_d;
            out_valid_q <= out_valid_d;
            bank_q      <= bank_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign load_sw   = load_sw_q;
    assign coff_out  = coff_q;
    assign fir_din   = fir_din_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fir_ctrl.sv
// Directed bench for fir_ctrl: a queue of due cycles predicts every out_valid, and the
// load/flush/run sequencing is checked step by step.
module tb_fir_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = '0;
    logic [7:0] cfg_data = '0;
    logic       reload = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_ready;
    logic       load_sw;
    logic [7:0] coff_out;
    logic [7:0] fir_din;
    logic       out_valid;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int dueQ[$];

    fir_ctrl #(.FIR_TAP(4), .COEF_WIDTH(8), .DIN_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .reload(reload), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .load_sw(load_sw), .coff_out(coff_out), .fir_din(fir_din),
        .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advances one clock and checks out_valid against the scoreboard's next due cycle.
    task automatic tick();
        logic expV;
        @(posedge clk);
        cyc++;
        #1;
        expV = 1'b0;
        if (dueQ.size() > 0 && dueQ[0] == cyc) begin
            expV = 1'b1;
            void'(dueQ.pop_front());
        end
        checkOutput("out_valid", out_valid, expV);
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic rel,
                                 input logic we = 1'b0, input logic [1:0] a = 2'd0,
                                 input logic [7:0] cd = 8'd0);
        logic hs;
        s_valid  = v;
        s_data   = d;
        reload   = rel;
        cfg_we   = we;
        cfg_addr = a;
        cfg_data = cd;
        hs = v && s_ready;
        tick();
        s_valid = 1'b0;
        reload  = 1'b0;
        cfg_we  = 1'b0;
        if (hs && !rel) dueQ.push_back(cyc + 2);
        checkOutput("fir_din", fir_din, hs ? d : 8'd0);
    endtask

    // Called in the first LOAD cycle; walks LOAD and FLUSH and ends in the first RUN cycle.
    task automatic loadAndFlush(input logic [31:0] coefs, input logic flushReload, input logic dropWrite);
        for (int i = 0; i < 4; i++) begin
            checkOutput("load_sw_load", load_sw, 0);
            checkOutput("coff_out", coff_out, coefs[8*i +: 8]);
            checkOutput("busy_load", busy, 1);
            applyStimulus(1'b0, 8'd0, 1'b0, dropWrite && i == 1, 2'd2, 8'h99);
        end
        for (int i = 0; i < 6; i++) begin
            checkOutput("busy_flush", busy, 1);
            checkOutput("load_sw_flush", load_sw, 1);
            checkOutput("s_ready_flush", s_ready, 0);
            applyStimulus(1'b0, 8'd0, flushReload && i == 2);
        end
        checkOutput("s_ready_run", s_ready, 1);
        checkOutput("busy_run", busy, 0);
        checkOutput("load_sw_run", load_sw, 1);
        checkOutput("coff_hold", coff_out, coefs[31:24]);
    endtask

    initial begin
        tick();
        tick();
        checkOutput("rst_load_sw", load_sw, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_s_ready", s_ready, 0);
        checkOutput("rst_coff", coff_out, 0);
        checkOutput("rst_fir_din", fir_din, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 2'(i), 8'(i + 1));
        end
        checkOutput("idle_s_ready", s_ready, 0);
        checkOutput("idle_load_sw", load_sw, 1);

        // Offered samples in IDLE are not accepted.
        applyStimulus(1'b1, 8'h77, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b1);
        loadAndFlush(32'h04030201, 1'b1, 1'b0);

        applyStimulus(1'b1, 8'h10, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'd0, 1'b0);

        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'd0, 1'b0);

        // Reload together with a handshake; a bank write during LOAD must be dropped.
        applyStimulus(1'b1, 8'h55, 1'b1);
        checkOutput("s_ready_after_reload", s_ready, 0);
        loadAndFlush(32'h04030201, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'd0, 1'b0);

        applyStimulus(1'b0, 8'd0, 1'b1);
        checkOutput("coff_l0", coff_out, 8'h01);
        applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("coff_l1", coff_out, 8'h02);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_load_sw", load_sw, 1);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_coff", coff_out, 0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'h33, 1'b0);
            checkOutput("post_abort_load_sw", load_sw, 1);
            checkOutput("post_abort_busy", busy, 0);
            checkOutput("post_abort_s_ready", s_ready, 0);
        end
        applyStimulus(1'b0, 8'd0, 1'b1);
        loadAndFlush(32'h00000000, 1'b0, 1'b0);
        checkOutput("scoreboard_empty", dueQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
